// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: same-cycle write bypass,
// hardwired zero register, per-register busy scoreboard and difftest view.
module regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NR   = 2,
    parameter int NW   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        wen,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*XLEN-1:0]   wdata,
    input  logic [NR-1:0]        ren,
    input  logic [NR*AW-1:0]     raddr,
    output logic [NR*XLEN-1:0]   rdata,
    output logic [NR-1:0]        rbusy,
    input  logic                 set_busy,
    input  logic [AW-1:0]        set_addr,
    input  logic                 flush,
    output logic [NREG*XLEN-1:0] regs_o
);

    if ((2 ** AW) < NREG) begin : g_bad_aw
        $error("regfile_mp: AW too narrow for NREG");
    end
    if (NW < 1 || NW > 4) begin : g_bad_nw
        $error("regfile_mp: NW must be in 1..4");
    end
    if (NREG < 2 || NREG > 32) begin : g_bad_nreg
        $error("regfile_mp: NREG must be in 2..32");
    end

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [NREG-1:0]           wr_hit;

    // regs_d is both the next storage state and the post-commit view; entry 0
    // is left untouched so the zero register can never be written.
    always_comb begin
        wr_hit = '0;
        regs_d = regs_q;
        for (int i = 1; i < NREG; i++) begin
            for (int k = 0; k < NW; k++) begin
                if (wen[k] && waddr[k*AW +: AW] == AW'(i)) begin
                    wr_hit[i] = 1'b1;
                    regs_d[i] = wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        busy_d = busy_d & ~wr_hit;
        for (int i = 1; i < NREG; i++) begin
            if (set_busy && set_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Only addresses 1..NREG-1 ever match, so x0 and invalid addresses read 0.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NR; j++) begin
            for (int i = 1; i < NREG; i++) begin
                if (raddr[j*AW +: AW] == AW'(i)) begin
                    if (ren[j]) begin
                        rdata[j*XLEN +: XLEN] = regs_d[i];
                    end
                    rbusy[j] = busy_q[i] & ~wr_hit[i];
                end
            end
        end
        if (rst) begin
            rdata = '0;
            rbusy = '0;
        end
    end

    assign regs_o = rst ? '0 : regs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// compared every cycle against an array-based model of the register file.
module tb_regfile_mp;
    localparam int XLEN = 64;
    localparam int NREG = 16;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NW-1:0]        wen;
    logic [NW*AW-1:0]     waddr;
    logic [NW*XLEN-1:0]   wdata;
    logic [NR-1:0]        ren;
    logic [NR*AW-1:0]     raddr;
    logic [NR*XLEN-1:0]   rdata;
    logic [NR-1:0]        rbusy;
    logic                 set_busy;
    logic [AW-1:0]        set_addr;
    logic                 flush;
    logic [NREG*XLEN-1:0] regs_o;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NR(NR), .NW(NW)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .set_busy(set_busy), .set_addr(set_addr), .flush(flush), .regs_o(regs_o)
    );

    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    int tests = 0;
    int fails = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Highest-index enabled port writing a valid non-zero register r wins.
    function automatic logic wr_match(input int r, output logic [XLEN-1:0] val);
        logic hit;
        hit = 1'b0;
        val = '0;
        for (int k = 0; k < NW; k++) begin
            if (wen[k] && r != 0 && r < NREG && int'(waddr[k*AW +: AW]) == r) begin
                hit = 1'b1;
                val = wdata[k*XLEN +: XLEN];
            end
        end
        return hit;
    endfunction

    function automatic logic [XLEN-1:0] exp_reg(input int r);
        logic [XLEN-1:0] v;
        if (rst) return '0;
        if (wr_match(r, v)) return v;
        return m_regs[r];
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input int j);
        int a;
        a = int'(raddr[j*AW +: AW]);
        if (rst || !ren[j] || a == 0 || a >= NREG) return '0;
        return exp_reg(a);
    endfunction

    function automatic logic exp_rbusy(input int j);
        int a;
        logic [XLEN-1:0] v;
        a = int'(raddr[j*AW +: AW]);
        if (rst || a == 0 || a >= NREG) return 1'b0;
        if (wr_match(a, v)) return 1'b0;
        return m_busy[a];
    endfunction

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    end

    always @(posedge clk) begin : model_update
        logic [XLEN-1:0] v;
        logic hit;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                hit = wr_match(r, v);
                if (flush) m_busy[r] = 1'b0;
                if (hit) m_busy[r] = 1'b0;
                if (set_busy && int'(set_addr) == r) m_busy[r] = 1'b1;
                if (hit) m_regs[r] = v;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int j = 0; j < NR; j++) begin
                chk($sformatf("rdata%0d", j), rdata[j*XLEN +: XLEN], exp_rdata(j));
                chk($sformatf("rbusy%0d", j), XLEN'(rbusy[j]), XLEN'(exp_rbusy(j)));
            end
            for (int i = 0; i < NREG; i++) begin
                chk($sformatf("regs_o[%0d]", i), regs_o[i*XLEN +: XLEN], exp_reg(i));
            end
        end
    end

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
        set_busy = 1'b0; set_addr = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic wr(input int k, input int a, input logic [XLEN-1:0] d);
        wen[k] = 1'b1;
        waddr[k*AW +: AW] = AW'(a);
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int j, input int a);
        ren[j] = 1'b1;
        raddr[j*AW +: AW] = AW'(a);
    endtask

    task automatic sb(input int a);
        set_busy = 1'b1;
        set_addr = AW'(a);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        wr(0, 3, 64'hAA);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_regs_o_a", regs_o[XLEN-1:0] | regs_o[3*XLEN +: XLEN], '0);
        @(negedge clk);
        chk("reset_regs_o_b", XLEN'(regs_o != '0), '0);
        rst = 1'b0;
        idle();
        rd(0, 3);
        @(negedge clk);
        chk("x3_after_reset", rdata[0 +: XLEN], '0);
        chk("x3_busy_after_reset", XLEN'(rbusy[0]), '0);
        chk("regs_o_after_reset", XLEN'(regs_o != '0), '0);

        step(); wr(0, 5, 64'h1234); rd(0, 5);
        @(negedge clk); chk("bypass_x5", rdata[0 +: XLEN], 64'h1234);
        step(); rd(0, 5);
        @(negedge clk); chk("stored_x5", rdata[0 +: XLEN], 64'h1234);
        chk("regs_o_x5", regs_o[5*XLEN +: XLEN], 64'h1234);

        step(); wr(0, 0, 64'hFFFF); rd(0, 0);
        @(negedge clk); chk("x0_bypass", rdata[0 +: XLEN], '0);
        chk("regs_o_x0", regs_o[0 +: XLEN], '0);
        step(); rd(0, 0);
        @(negedge clk); chk("x0_stored", rdata[0 +: XLEN], '0);

        step(); wr(0, 7, 64'h11); wr(1, 7, 64'h22); rd(0, 7);
        @(negedge clk); chk("conflict_bypass", rdata[0 +: XLEN], 64'h22);
        step(); rd(0, 7);
        @(negedge clk); chk("conflict_stored", rdata[0 +: XLEN], 64'h22);
        step(); wr(0, 8, 64'h33); rd(1, 8);
        @(negedge clk); chk("port0_only_bypass", rdata[XLEN +: XLEN], 64'h33);
        step(); rd(1, 8);
        @(negedge clk); chk("port0_only_stored", rdata[XLEN +: XLEN], 64'h33);

        step(); sb(9); rd(1, 9);
        @(negedge clk); chk("set_not_yet_visible", XLEN'(rbusy[1]), '0);
        step(); rd(1, 9);
        @(negedge clk); chk("x9_busy", XLEN'(rbusy[1]), 1);
        step(); wr(0, 9, 64'h99); rd(1, 9);
        @(negedge clk); chk("x9_write_hides_busy", XLEN'(rbusy[1]), '0);
        step(); rd(1, 9);
        @(negedge clk); chk("x9_cleared", XLEN'(rbusy[1]), '0);
        step(); wr(0, 9, 64'h9A); sb(9);
        step(); rd(1, 9);
        @(negedge clk); chk("set_beats_write", XLEN'(rbusy[1]), 1);

        step(); sb(4);
        step(); sb(6);
        step(); sb(10);
        step(); flush = 1'b1; sb(6); rd(0, 4); rd(1, 10);
        @(negedge clk); chk("x4_busy_pre_flush", XLEN'(rbusy[0]), 1);
        chk("x10_busy_pre_flush", XLEN'(rbusy[1]), 1);
        step(); rd(0, 4); rd(1, 10);
        @(negedge clk); chk("x4_flushed", XLEN'(rbusy[0]), '0);
        chk("x10_flushed", XLEN'(rbusy[1]), '0);
        step(); rd(0, 6); rd(1, 9);
        @(negedge clk); chk("x6_set_beats_flush", XLEN'(rbusy[0]), 1);
        chk("x9_flushed", XLEN'(rbusy[1]), '0);

        step(); wr(0, 20, 64'h55); rd(0, 20); rd(1, 4);
        @(negedge clk); chk("invalid_read", rdata[0 +: XLEN], '0);
        chk("invalid_rbusy", XLEN'(rbusy[0]), '0);
        chk("alias_x4_bypass", rdata[XLEN +: XLEN], '0);
        step(); rd(1, 4);
        @(negedge clk); chk("alias_x4_stored", rdata[XLEN +: XLEN], '0);
        chk("regs_o_x4", regs_o[4*XLEN +: XLEN], '0);
        chk("regs_o_x7", regs_o[7*XLEN +: XLEN], 64'h22);
        chk("regs_o_x9", regs_o[9*XLEN +: XLEN], 64'h9A);
        step(); sb(20);
        step(); rd(0, 20); rd(1, 4);
        @(negedge clk); chk("invalid_set_busy", XLEN'(rbusy[0]), '0);
        chk("alias_x4_not_busy", XLEN'(rbusy[1]), '0);

        for (int n = 0; n < 2000; n++) begin
            step();
            rst = ($urandom_range(0, 63) == 0);
            wen = NW'($urandom);
            for (int k = 0; k < NW; k++) begin
                waddr[k*AW +: AW] = AW'($urandom_range(0, NREG + 5));
                wdata[k*XLEN +: XLEN] = {$urandom, $urandom};
            end
            ren = NR'($urandom);
            for (int j = 0; j < NR; j++) begin
                raddr[j*AW +: AW] = AW'($urandom_range(0, NREG + 5));
            end
            set_busy = ($urandom_range(0, 2) == 0);
            set_addr = AW'($urandom_range(0, NREG + 5));
            flush = ($urandom_range(0, 15) == 0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation core pipeline. It replaces the fixed 2-read/1-write, 64x32 file. It provides NR read ports and NW write ports with same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for issue-stage hazard checks. It also exports a post-write architectural view for difftest.

Parameters:
XLEN, 64, register data width in bits
NREG, 32, number of architectural registers (2..32)
AW, 5, register address width; must satisfy 2**AW >= NREG
NR, 2, number of read ports
NW, 1, number of write ports (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
wen  in  NW  per-port write enable
waddr  in  NW*AW  write addresses; port k occupies bits [k*AW +: AW]
wdata  in  NW*XLEN  write data; port k occupies bits [k*XLEN +: XLEN]
ren  in  NR  per-port read enable
raddr  in  NR*AW  read addresses, packed the same way as waddr
rdata  out  NR*XLEN  read data, combinational
rbusy  out  NR  scoreboard busy bit for each read address, combinational
set_busy  in  1  mark register set_addr busy (issue of a producer)
set_addr  in  AW  register to mark busy
flush  in  1  clear the whole scoreboard (pipeline flush)
regs_o  out  NREG*XLEN  difftest view; register i occupies bits [i*XLEN +: XLEN]

Behaviour:
- Reset (rst=1 at a clock edge): all registers are set to 0 and all busy bits are cleared. While rst=1, rdata, rbusy and regs_o are forced to 0 combinationally. Writes and set_busy in a reset cycle are ignored.
- Register 0 always reads as 0, is never written, and is never busy.
- An address >= NREG is invalid. Writes to it are dropped, reads return 0, rbusy returns 0, and set_busy to it is ignored.
- Write:
  - At the clock edge, each port k with wen[k]=1 and a valid, non-zero waddr updates its register.
  - If several ports target the same register in one cycle, the highest-index port wins.
  - Write latency is one cycle to the storage array, but writes are visible to reads in the same cycle through the bypass.
- Read port j:
  - ren[j]=0, address 0, or an invalid address gives rdata = 0.
  - Otherwise, if any enabled write port targets raddr[j] this cycle, rdata = wdata of the highest-index matching write port.
  - Otherwise, rdata = the stored value.
  - Reads are purely combinational, with zero latency.
- Scoreboard, per register r, evaluated at the clock edge:
  - The next busy bit is computed in this order: start from the current bit; apply flush (clears all); apply clear on write (wen to r clears it); apply set (set_busy with set_addr=r sets it).
  - So set wins over both a same-cycle write and flush for the same register (a new producer is issued).
- rbusy[j] = busy[raddr[j]], except it reads 0 when a write to that address occurs in the same cycle (the value is bypassed). A same-cycle set_busy does not affect rbusy until the next cycle. rbusy ignores ren.
- regs_o[i] = the highest-index matching wdata if register i is being written this cycle (i != 0), else the stored value. This is the post-commit view for difftest.
- There are no X outputs for any legal input. Parameter checks (AW, NW range) are made by elaboration-time assertions.

Test Plan:
- Reset: hold rst for 2 cycles with wen=1, waddr=3, wdata=0xAA. Release, then read x3 -> rdata=0, rbusy=0. Every slice of regs_o=0 during and after reset.
- Write/read and bypass: write x5=0x1234 in cycle 0 and read x5 in the same cycle -> 0x1234 (bypass). In cycle 1, with no write, read -> 0x1234. Write x0=0xFFFF, then read x0 -> 0 and regs_o slice 0 = 0.
- Multi-write conflict (NW=2): in one cycle write port0 x7=0x11 and port1 x7=0x22 -> same-cycle read 0x22 and stored 0x22. Port0 x8=0x33 with port1 idle -> x8=0x33.
- Scoreboard: set_busy x9 -> next cycle rbusy=1. Write x9 -> rbusy=0 in the same cycle, busy cleared next cycle. Apply set_busy x9 and a write to x9 in the same cycle -> busy=1 afterwards.
- Flush: set x4, x6 and x10 busy. Assert flush together with set_busy x6 -> next cycle x4=0, x10=0, x6=1.
- Invalid address (NREG=16, AW=5): write x20=0x55 -> dropped, no regs_o change. Read x20 -> rdata=0, rbusy=0. set_busy x20 -> no effect.
